zmod_rx_checker: RTL and testbench

ZMOD_RX_CHECKER -- requirements
Module: zmod_rx_checker

---
 rtl/zmod_rx_checker.sv | 150 +++++++++++++++
 tb/tb_zmod_rx_checker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_rx_checker.sv
// Alignment and lock checker for an incrementing test pattern on the IDDR word.
// Searches over the two half-cycle alignments, then counts mismatches while locked.
module zmod_rx_checker #(
  parameter int LOCK_CNT       = 16,
  parameter int ERR_LIMIT      = 4,
  parameter int SEARCH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        clear,
  output logic        locked,
  output logic        slip,
  output logic        err_pulse,
  output logic [31:0] err_cnt,
  output logic [47:0] word_cnt,
  output logic [15:0] lost_cnt,
  output logic [15:0] slip_cnt
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]  state, state_n;
  logic        seeded, seeded_n, slip_n;
  logic [7:0]  din_prev, ref_w, ref_inc, w;
  logic [15:0] run_cnt, run_n, run_inc;
  logic [15:0] bad_cnt, bad_n, bad_inc;
  logic [15:0] to_cnt, to_n, to_inc;
  logic        match;
  logic        err_inc, word_inc, lost_inc, slip_inc;

  assign locked  = state;
  assign ref_inc = ref_w + 8'd1;
  assign run_inc = run_cnt + 16'd1;
  assign bad_inc = bad_cnt + 16'd1;
  assign to_inc  = to_cnt + 16'd1;

  // slip=1 pairs this word's first half with the previous word's second half
  always_comb begin
    w = din;
    if (slip) begin
      for (int i = 0; i < 4; i++) begin
        w[2*i+1] = din[2*i];
        w[2*i]   = din_prev[2*i+1];
      end
    end
  end

  assign match = seeded && (w == ref_inc);

  always_comb begin
    state_n  = state;
    seeded_n = seeded;
    slip_n   = slip;
    run_n    = run_cnt;
    bad_n    = bad_cnt;
    to_n     = to_cnt;
    err_inc  = 1'b0;
    word_inc = 1'b0;
    lost_inc = 1'b0;
    slip_inc = 1'b0;
    if (din_valid) begin
      seeded_n = 1'b1;
      unique case (state)
        SEARCH: begin
          to_n  = to_inc;
          run_n = match ? run_inc : 16'd0;
          if (match && run_inc == 16'(LOCK_CNT)) begin
            state_n = LOCKED;
            run_n   = 16'd0;
            to_n    = 16'd0;
          end else if (to_inc == 16'(SEARCH_TIMEOUT)) begin
            slip_n   = ~slip;
            slip_inc = 1'b1;
            run_n    = 16'd0;
            to_n     = 16'd0;
            seeded_n = 1'b0;
          end
        end
        LOCKED: begin
          word_inc = 1'b1;
          if (match) begin
            bad_n = 16'd0;
          end else begin
            err_inc = 1'b1;
            bad_n   = bad_inc;
            if (bad_inc == 16'(ERR_LIMIT)) begin
              state_n  = SEARCH;
              lost_inc = 1'b1;
              bad_n    = 16'd0;
              run_n    = 16'd0;
              to_n     = 16'd0;
              seeded_n = 1'b0;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      seeded    <= 1'b0;
      slip      <= 1'b0;
      din_prev  <= 8'd0;
      ref_w     <= 8'd0;
      run_cnt   <= 16'd0;
      bad_cnt   <= 16'd0;
      to_cnt    <= 16'd0;
      err_pulse <= 1'b0;
      err_cnt   <= 32'd0;
      word_cnt  <= 48'd0;
      lost_cnt  <= 16'd0;
      slip_cnt  <= 16'd0;
    end else begin
      state     <= state_n;
      seeded    <= seeded_n;
      slip      <= slip_n;
      run_cnt   <= run_n;
      bad_cnt   <= bad_n;
      to_cnt    <= to_n;
      err_pulse <= err_inc;
      if (din_valid) begin
        din_prev <= din;
        ref_w    <= w;
      end
      if (clear)
        err_cnt <= 32'd0;
      else if (err_inc && err_cnt != '1)
        err_cnt <= err_cnt + 32'd1;
      if (clear)
        word_cnt <= 48'd0;
      else if (word_inc)
        word_cnt <= word_cnt + 48'd1;
      if (clear)
        lost_cnt <= 16'd0;
      else if (lost_inc && lost_cnt != '1)
        lost_cnt <= lost_cnt + 16'd1;
      if (clear)
        slip_cnt <= 16'd0;
      else if (slip_inc && slip_cnt != '1)
        slip_cnt <= slip_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_zmod_rx_checker.sv
// Bench for zmod_rx_checker: behavioural model scoreboard plus
// directed lock, slip, error, wrap, clear and reset sequences.
module tb_zmod_rx_checker;

  localparam int LCNT = 16;
  localparam int ELIM = 4;
  localparam int STO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, slip, err_pulse;
  logic [31:0] err_cnt;
  logic [47:0] word_cnt;
  logic [15:0] lost_cnt, slip_cnt;

  zmod_rx_checker #(
    .LOCK_CNT(LCNT), .ERR_LIMIT(ELIM), .SEARCH_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .clear(clear), .locked(locked), .slip(slip), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .word_cnt(word_cnt), .lost_cnt(lost_cnt),
    .slip_cnt(slip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk, sl, pu;
    logic [31:0] err;
    logic [47:0] word;
    logic [15:0] lost, slc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       e_lk;
    logic       e_pu;
    int         e_wd;
  } vec_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  logic        m_lock, m_slip, m_pulse, m_seeded;
  logic [7:0]  m_prev, m_ref;
  int          m_run, m_bad, m_to;
  logic [31:0] m_err;
  logic [47:0] m_word;
  logic [15:0] m_lost, m_slc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_slip = 0; m_pulse = 0; m_seeded = 0;
    m_prev = 0; m_ref = 0; m_run = 0; m_bad = 0; m_to = 0;
    m_err = 0; m_word = 0; m_lost = 0; m_slc = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic v,
                            input logic c);
    logic [7:0] w;
    logic hit;
    exp_t e;
    m_pulse = 0;
    if (v) begin
      w = d;
      if (m_slip)
        for (int i = 0; i < 4; i++) begin
          w[2*i+1] = d[2*i];
          w[2*i]   = m_prev[2*i+1];
        end
      hit = m_seeded && (w == 8'(m_ref + 8'd1));
      if (!m_lock) begin
        m_to++;
        m_run = hit ? m_run + 1 : 0;
        if (m_run == LCNT) begin
          m_lock = 1; m_run = 0; m_to = 0; m_seeded = 1;
        end else if (m_to == STO) begin
          m_slip = ~m_slip; m_run = 0; m_to = 0; m_seeded = 0;
          if (m_slc != '1) m_slc++;
        end else m_seeded = 1;
      end else begin
        m_word++;
        if (hit) m_bad = 0;
        else begin
          m_pulse = 1;
          if (m_err != '1) m_err++;
          m_bad++;
          if (m_bad == ELIM) begin
            m_lock = 0; m_bad = 0; m_seeded = 0;
            if (m_lost != '1) m_lost++;
          end
        end
      end
      m_prev = d;
      m_ref = w;
    end
    if (c) begin
      m_err = 0; m_word = 0; m_lost = 0; m_slc = 0;
    end
    e = '{m_lock, m_slip, m_pulse, m_err, m_word, m_lost, m_slc};
    sbq.push_back(e);
  endtask

  task automatic step(input logic [7:0] d, input logic v = 1'b1,
                      input logic c = 1'b0);
    exp_t e;
    @(negedge clk);
    din = d; din_valid = v; clear = c;
    model_step(d, v, c);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_locked", 64'(locked), 64'(e.lk));
    chk("sb_slip", 64'(slip), 64'(e.sl));
    chk("sb_err_pulse", 64'(err_pulse), 64'(e.pu));
    chk("sb_err_cnt", 64'(err_cnt), 64'(e.err));
    chk("sb_word_cnt", 64'(word_cnt), 64'(e.word));
    chk("sb_lost_cnt", 64'(lost_cnt), 64'(e.lost));
    chk("sb_slip_cnt", 64'(slip_cnt), 64'(e.slc));
  endtask

  task automatic chk_zero(input string nm);
    logic [63:0] z;
    z = 64'(locked) | 64'(slip) | 64'(err_pulse) | 64'(err_cnt)
      | 64'(word_cnt) | 64'(lost_cnt) | 64'(slip_cnt);
    chk(nm, z, 64'd0);
  endtask

  // async reset pulse placed between clock edges
  task automatic async_reset();
    #2 rst_n = 1'b0;
    din_valid = 1'b0; clear = 1'b0;
    #1 chk_zero("reset_outputs_zero");
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] shifted(input int k);
    logic [7:0] a, b, r;
    a = 8'(k);
    b = 8'(k + 1);
    for (int i = 0; i < 4; i++) begin
      r[2*i]   = a[2*i+1];
      r[2*i+1] = b[2*i];
    end
    return r;
  endfunction

  vec_t tbl[7];
  int base;

  initial begin
    tbl[0] = '{8'hFE, 1'b1, 1'b1, 1'b0, 1};
    tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2};
    tbl[3] = '{8'h5A, 1'b0, 1'b1, 1'b0, 2};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 3};
    tbl[5] = '{8'hC3, 1'b0, 1'b1, 1'b0, 3};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 4};

    model_reset();
    #12 chk_zero("initial_reset_zero");
    @(negedge clk);
    rst_n = 1'b1;

    // lock from an incrementing stream
    for (int k = 0; k < 16; k++) step(8'(k));
    chk("lock_not_before_17th", 64'(locked), 64'd0);
    step(8'd16);
    chk("lock_after_17th", 64'(locked), 64'd1);
    chk("lock_err_cnt", 64'(err_cnt), 64'd0);

    base = 0;
    for (int k = 17; k <= 253; k++) begin
      step(8'(k));
      base++;
    end
    chk("word_cnt_before_wrap", 64'(word_cnt), 64'(base));

    // wrap with valid toggling
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].v);
      chk("wrap_locked", 64'(locked), 64'(tbl[i].e_lk));
      chk("wrap_err_pulse", 64'(err_pulse), 64'(tbl[i].e_pu));
      chk("wrap_word_cnt", 64'(word_cnt), 64'(base + tbl[i].e_wd));
    end
    chk("wrap_err_cnt", 64'(err_cnt), 64'd0);

    // single corrupted word
    step(8'h02);
    step(8'h77);
    chk("corrupt_pulse", 64'(err_pulse), 64'd1);
    chk("corrupt_err1", 64'(err_cnt), 64'd1);
    step(8'h04);
    chk("corrupt_err2", 64'(err_cnt), 64'd2);
    step(8'h05);
    chk("corrupt_pulse_low", 64'(err_pulse), 64'd0);
    chk("corrupt_err_final", 64'(err_cnt), 64'd2);
    chk("corrupt_still_locked", 64'(locked), 64'd1);

    // clear on a mismatch cycle
    step(8'h06);
    step(8'h33, 1'b1, 1'b1);
    chk("clear_err_cnt", 64'(err_cnt), 64'd0);
    chk("clear_word_cnt", 64'(word_cnt), 64'd0);
    chk("clear_keeps_lock", 64'(locked), 64'd1);
    step(8'h08);
    chk("after_clear_err", 64'(err_cnt), 64'd1);
    step(8'h09);

    // loss of lock
    for (int k = 0; k < 4; k++) step(8'h09);
    chk("lost_unlocked", 64'(locked), 64'd0);
    chk("lost_cnt", 64'(lost_cnt), 64'd1);

    // relock then reset mid-lock
    for (int k = 8'h80; k <= 8'h90; k++) step(8'(k));
    chk("relock", 64'(locked), 64'd1);
    async_reset();
    for (int k = 8'h91; k <= 8'hA1; k++) step(8'(k));
    chk("relock_after_reset", 64'(locked), 64'd1);
    chk("relock_err_cnt", 64'(err_cnt), 64'd0);
    chk("relock_lost_cnt", 64'(lost_cnt), 64'd0);

    // half-cycle shifted lanes force a slip
    async_reset();
    for (int k = 0; k < 63; k++) step(shifted(k));
    chk("slip_not_yet", 64'(slip), 64'd0);
    step(shifted(63));
    chk("slip_set", 64'(slip), 64'd1);
    chk("slip_cnt", 64'(slip_cnt), 64'd1);
    for (int k = 64; k < 84; k++) step(shifted(k));
    chk("slip_locked", 64'(locked), 64'd1);
    chk("slip_err_cnt", 64'(err_cnt), 64'd0);
    chk("slip_cnt_final", 64'(slip_cnt), 64'd1);

    @(negedge clk);
    din_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
